clock_observer: RTL

- Receiver-side counterpart of the generated-clock path. Samples a clock produced elsewhere (possibly paused, possibly asynchronous), synchronises it into the local domain, and flags its rising and falling edges.
- Measures the high and low half-periods in clk_en-qualified cycles and detects when the observed clock has paused, including the level it paused at.
- Feeds rate checkers and protocol slaves that must know whether a generated clock is running.

---
 rtl/clock_observer_pkg.sv | 15 +
 rtl/sync_chain.sv | 28 ++
 rtl/clock_observer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/clock_observer_pkg.sv
// Shared types for the clock observer.
//   obs_state_e     : observer FSM states (IDLE, ACQUIRE, MEASURE, PAUSED)
//   MIN_SYNC_STAGES : fewest flops allowed in an async-input synchroniser
package clock_observer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    PAUSED  = 2'd3
  } obs_state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit. It is reused by
// other blocks for their asynchronous inputs.
//   clk    in  : destination clock, the chain shifts on every edge
//   rst_n  in  : asynchronous active-low reset, clears every stage to 0
//   d      in  : asynchronous input bit
//   q      out : synchronised bit, STAGES clk cycles after d is sampled
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/clock_observer.sv
// Receiver-side observer for a generated clock. The observed clock is
// synchronised into clk, its edges are flagged, its high and low half-periods
// are measured in clk_en-qualified cycles, and a pause (no edge for
// timeout_i qualified cycles) is reported together with the level it
// stopped at.
//   clk               in  : system clock
//   async_rst_n       in  : asynchronous active-low reset
//   clk_en            in  : cycle qualifier; only the synchroniser runs without it
//   enable_i          in  : observer enable, low returns to IDLE
//   sample_i          in  : observed clock, asynchronous to clk
//   timeout_i         in  : pause threshold in qualified cycles, 0 disables
//   state_o           out : synchronised, edge-tracked level of sample_i
//   rise_o / fall_o   out : one-cycle pulse per detected edge
//   high_count_o      out : last measured high half-period
//   low_count_o       out : last measured low half-period
//   period_valid_o    out : both counts hold real measurements
//   paused_o          out : observed clock is paused
//   paused_polarity_o out : level at which the last pause began
module clock_observer
  import clock_observer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               clk_en,
  input  logic               enable_i,
  input  logic               sample_i,
  input  logic [COUNT_W-1:0] timeout_i,
  output logic               state_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic [COUNT_W-1:0] high_count_o,
  output logic [COUNT_W-1:0] low_count_o,
  output logic               period_valid_o,
  output logic               paused_o,
  output logic               paused_polarity_o
);

  // A chain shorter than two flops is not a synchroniser; clamp it.
  localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  // Half-period counter increment that sticks at full scale, so a clock
  // stopped longer than the counter range still reads as "max".
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic               sync_lvl;
  logic               hist_q;
  logic               edge_rise;
  logic               edge_fall;
  logic               edge_any;
  logic [COUNT_W-1:0] count_q;
  logic               high_ok;
  logic               low_ok;
  obs_state_e         state_q;

  // ---- stage 0: synchroniser, free-running on every clk ----
  sync_chain #(
    .STAGES (SYNC_N)
  ) u_sync (
    .clk   (clk),
    .rst_n (async_rst_n),
    .d     (sample_i),
    .q     (sync_lvl)
  );

  // Edges are evaluated only on qualified cycles. Because hist_q also only
  // loads on qualified cycles, a level change that arrives during a clk_en
  // gap is still seen as an edge on the next qualified cycle.
  assign edge_rise = clk_en &  sync_lvl & ~hist_q;
  assign edge_fall = clk_en & ~sync_lvl &  hist_q;
  assign edge_any  = edge_rise | edge_fall;

  // ---- stage 1: history flop and registered edge pulses ----
  // The pulses are written every clk so they last exactly one cycle even
  // when clk_en is held high for a long stretch or dropped right after.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      hist_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      if (clk_en) begin
        hist_q <= sync_lvl;
      end
      rise_o <= edge_rise;
      fall_o <= edge_fall;
    end
  end

  assign state_o = hist_q;

  // ---- stage 1: observer FSM, counter and measurement registers ----
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q           <= IDLE;
      count_q           <= '0;
      high_count_o      <= '0;
      low_count_o       <= '0;
      high_ok           <= 1'b0;
      low_ok            <= 1'b0;
      period_valid_o    <= 1'b0;
      paused_o          <= 1'b0;
      paused_polarity_o <= 1'b0;
    end else if (clk_en) begin
      if (!enable_i) begin
        // Dropping enable wins over any edge this cycle: the edge is still
        // pulsed above, but nothing is captured. The pause polarity is
        // left as a record of the last pause.
        state_q        <= IDLE;
        count_q        <= '0;
        high_count_o   <= '0;
        low_count_o    <= '0;
        high_ok        <= 1'b0;
        low_ok         <= 1'b0;
        period_valid_o <= 1'b0;
        paused_o       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q <= '0;
            state_q <= ACQUIRE;
          end

          ACQUIRE: begin
            // The first edge only marks a starting point; the half-period
            // before it was not fully observed.
            if (edge_any) begin
              count_q <= CNT_ONE;
              state_q <= MEASURE;
            end
          end

          MEASURE: begin
            if (edge_any) begin
              count_q <= CNT_ONE;
              // A rising edge ends a low half-period and vice versa.
              if (edge_rise) begin
                low_count_o <= count_q;
                low_ok      <= 1'b1;
              end
              if (edge_fall) begin
                high_count_o <= count_q;
                high_ok      <= 1'b1;
              end
              period_valid_o <= (high_ok | edge_fall) & (low_ok | edge_rise);
            end else if ((timeout_i != '0) && (count_q >= timeout_i)) begin
              count_q           <= sat_inc(count_q);
              state_q           <= PAUSED;
              paused_o          <= 1'b1;
              paused_polarity_o <= hist_q;
            end else begin
              count_q <= sat_inc(count_q);
            end
          end

          PAUSED: begin
            // Only an edge leaves PAUSED, whatever timeout_i does. The
            // stalled half-period is meaningless and is not captured.
            if (edge_any) begin
              count_q  <= CNT_ONE;
              state_q  <= MEASURE;
              paused_o <= 1'b0;
            end else begin
              count_q <= sat_inc(count_q);
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
